// File: rtl/lcd_char_writer_if.sv
// Bus between lcd_char_writer, the HD44780 4-bit panel pins and the
// display-content mux that turns a DDRAM index into a character code.
interface lcd_char_writer_if;
  // index is driven one cycle before char is sampled, and char must be a pure
  // combinational function of index. ready is a level, not a handshake: it
  // rises once init completes and holds until reset.
  logic [7:0] char;
  logic [7:0] index;
  logic       rs;
  logic       rw;
  logic       enable;
  logic [3:0] lcd_data;
  logic       ready;
  logic [2:0] top_state;
  logic [2:0] byte_state;

  modport master (
    input  char,
    output index, rs, rw, enable, lcd_data, ready, top_state, byte_state
  );

  modport slave (
    output char,
    input  index, rs, rw, enable, lcd_data, ready, top_state, byte_state
  );
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 4-bit write-only front end: power-up init, then endless two-line refresh.
// Optional LCD_FRAME_DONE_EN adds a frame_done pulse after the last char of line 2.
module lcd_char_writer #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_SETUP   = 2,
  parameter int T_EHIGH   = 12,
  parameter int T_GAP     = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic clk,
  input  logic rst,
  lcd_char_writer_if.master bus
`ifdef LCD_FRAME_DONE_EN
  ,
  output logic frame_done
`endif
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_INIT1), max2(T_INIT2, T_SETUP)),
                              max2(max2(T_EHIGH, T_GAP), max2(T_CMD, T_CLEAR)));
  localparam int TW = $clog2(T_MAX + 1);

  typedef logic [TW-1:0] tmr_t;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    INIT_NIB = 3'd1,
    CFG      = 3'd2,
    SET_ADDR = 3'd3,
    WR_CHAR  = 3'd4
  } top_t;

  typedef enum logic [2:0] {
    B_IDLE  = 3'd0,
    B_SETUP = 3'd1,
    B_EHI   = 3'd2,
    B_GAP   = 3'd3,
    B_WAIT  = 3'd4,
    B_NEXT  = 3'd5
  } byte_t;

  top_t       top;
  byte_t      bst;
  tmr_t       timer;
  logic [1:0] step;
  logic       lower;
  logic       nib_only;
  logic [7:0] byte_q;
  logic       rs_q;
  logic       en_q;
  logic [3:0] data_q;
  logic [7:0] index_q;
  logic       ready_q;

  logic [7:0] next_byte;
  logic       next_rs;
  tmr_t       wait_len;
  logic [7:0] char_safe;

  // Next byte to send and the wait that follows the byte currently on the bus.
  always_comb begin
    char_safe = (bus.char < 8'h20) ? 8'h20 : bus.char;
    next_byte = 8'h00;
    next_rs   = 1'b0;
    wait_len  = tmr_t'(T_CMD - 1);
    case (top)
      INIT_NIB: begin
        next_byte = (step == 2'd3) ? 8'h20 : 8'h30;
        if (step == 2'd0)      wait_len = tmr_t'(T_INIT1 - 1);
        else if (step == 2'd1) wait_len = tmr_t'(T_INIT2 - 1);
      end
      CFG: begin
        case (step)
          2'd0:    next_byte = 8'h28;
          2'd1:    next_byte = 8'h06;
          2'd2:    next_byte = 8'h0C;
          default: next_byte = 8'h01;
        endcase
        if (step == 2'd3) wait_len = tmr_t'(T_CLEAR - 1);
      end
      SET_ADDR: next_byte = 8'h80 | index_q;
      WR_CHAR: begin
        next_byte = char_safe;
        next_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top      <= PWR_WAIT;
      bst      <= B_IDLE;
      timer    <= tmr_t'(T_POWERUP - 1);
      step     <= 2'd0;
      lower    <= 1'b0;
      nib_only <= 1'b0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= 4'h0;
      index_q  <= 8'h00;
      ready_q  <= 1'b0;
`ifdef LCD_FRAME_DONE_EN
      frame_done <= 1'b0;
`endif
    end else begin
`ifdef LCD_FRAME_DONE_EN
      frame_done <= 1'b0;
`endif
      case (bst)
        B_IDLE: begin
          if (timer == '0) begin
            top      <= INIT_NIB;
            step     <= 2'd0;
            nib_only <= 1'b1;
            lower    <= 1'b0;
            byte_q   <= 8'h30;
            rs_q     <= 1'b0;
            data_q   <= 4'h3;
            bst      <= B_SETUP;
            timer    <= tmr_t'(T_SETUP - 1);
          end else begin
            timer <= timer - tmr_t'(1);
          end
        end
        B_SETUP: begin
          if (timer == '0) begin
            en_q  <= 1'b1;
            bst   <= B_EHI;
            timer <= tmr_t'(T_EHIGH - 1);
          end else begin
            timer <= timer - tmr_t'(1);
          end
        end
        B_EHI: begin
          if (timer == '0) begin
            en_q <= 1'b0;
            if (nib_only || lower) begin
              bst   <= B_WAIT;
              timer <= wait_len;
            end else begin
              bst   <= B_GAP;
              timer <= tmr_t'(T_GAP - 1);
            end
          end else begin
            timer <= timer - tmr_t'(1);
          end
        end
        B_GAP: begin
          if (timer == '0) begin
            lower  <= 1'b1;
            data_q <= byte_q[3:0];
            bst    <= B_SETUP;
            timer  <= tmr_t'(T_SETUP - 1);
          end else begin
            timer <= timer - tmr_t'(1);
          end
        end
        B_WAIT: begin
          if (timer == '0) begin
            bst <= B_NEXT;
            // Advance the sequence; index moves here so char settles before it is latched.
            case (top)
              INIT_NIB: begin
                if (step == 2'd3) begin
                  top  <= CFG;
                  step <= 2'd0;
                end else begin
                  step <= step + 2'd1;
                end
              end
              CFG: begin
                if (step == 2'd3) top <= SET_ADDR;
                else              step <= step + 2'd1;
              end
              SET_ADDR: top <= WR_CHAR;
              WR_CHAR: begin
                if (index_q[3:0] == 4'hF) begin
                  top     <= SET_ADDR;
                  index_q <= index_q[6] ? 8'h00 : 8'h40;
`ifdef LCD_FRAME_DONE_EN
                  frame_done <= index_q[6];
`endif
                end else begin
                  index_q <= index_q + 8'd1;
                end
              end
              default: ;
            endcase
          end else begin
            timer <= timer - tmr_t'(1);
          end
        end
        B_NEXT: begin
          if (top == SET_ADDR) ready_q <= 1'b1;
          nib_only <= (top == INIT_NIB);
          lower    <= 1'b0;
          byte_q   <= next_byte;
          rs_q     <= next_rs;
          data_q   <= next_byte[7:4];
          bst      <= B_SETUP;
          timer    <= tmr_t'(T_SETUP - 1);
        end
        default: begin
          bst   <= B_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign bus.index      = index_q;
  assign bus.rs         = rs_q;
  assign bus.rw         = 1'b0;
  assign bus.enable     = en_q;
  assign bus.lcd_data   = data_q;
  assign bus.ready      = ready_q;
  assign bus.top_state  = top;
  assign bus.byte_state = bst;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer: random char tables, a nibble-level reference
// sequence built from the display rules, timing checks on every E pulse.
module tb_lcd_char_writer;
  localparam int T_POWERUP = 20;
  localparam int T_INIT1   = 10;
  localparam int T_INIT2   = 8;
  localparam int T_SETUP   = 2;
  localparam int T_EHIGH   = 3;
  localparam int T_GAP     = 2;
  localparam int T_CMD     = 6;
  localparam int T_CLEAR   = 15;
  localparam int NIB_INIT  = 12;   // 4 init nibbles + 4 config bytes
  localparam int NIB_FRAME = 68;   // 2 lines x (address byte + 16 chars) x 2 nibbles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_char_writer_if bus();
`ifdef LCD_FRAME_DONE_EN
  logic frame_done;
`endif

  lcd_char_writer #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
    .T_EHIGH(T_EHIGH), .T_GAP(T_GAP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LCD_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  // Caller-side char lookup; during a data E pulse it returns noise, since the
  // byte must already be latched by then.
  logic [7:0] char_mem [0:127];
  logic [7:0] noise = 8'h00;

  always_comb bus.char = (bus.enable && bus.rs) ? noise : char_mem[bus.index[6:0]];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // entry = {wait after this nibble (0 = lower nibble follows), index, rs, nibble}
  logic [20:0] exp_q[$];

  function automatic void push_nib(input logic [3:0] nib, input logic rs_v,
                                   input logic [7:0] idx, input int w);
    exp_q.push_back({8'(w), idx, rs_v, nib});
  endfunction

  function automatic void push_byte(input logic [7:0] b, input logic rs_v,
                                    input logic [7:0] idx, input int w);
    push_nib(b[7:4], rs_v, idx, 0);
    push_nib(b[3:0], rs_v, idx, w);
  endfunction

  function automatic void build_expected(input int frames);
    exp_q.delete();
    push_nib(4'h3, 1'b0, 8'h00, T_INIT1);
    push_nib(4'h3, 1'b0, 8'h00, T_INIT2);
    push_nib(4'h3, 1'b0, 8'h00, T_CMD);
    push_nib(4'h2, 1'b0, 8'h00, T_CMD);
    push_byte(8'h28, 1'b0, 8'h00, T_CMD);
    push_byte(8'h06, 1'b0, 8'h00, T_CMD);
    push_byte(8'h0C, 1'b0, 8'h00, T_CMD);
    push_byte(8'h01, 1'b0, 8'h00, T_CLEAR);
    for (int f = 0; f < frames; f++) begin
      for (int line = 0; line < 2; line++) begin
        logic [7:0] base;
        base = (line == 1) ? 8'h40 : 8'h00;
        push_byte(8'h80 | base, 1'b0, base, T_CMD);
        for (int c = 0; c < 16; c++) begin
          logic [7:0] ch;
          ch = char_mem[int'(base) + c];
          if (ch < 8'h20) ch = 8'h20;
          push_byte(ch, 1'b1, base + 8'(c), T_CMD);
        end
      end
    end
  endfunction

  // ---------------- bus monitor (called once per negedge) ----------------
  logic       prev_en, prev_ready;
  logic [4:0] prev_bus;
  int last_chg, rise_cyc, last_fall, clear_fall, cur_wait, nib_cnt, rel_cyc, fd_cnt;
  logic [7:0] last_idx;

  task automatic monitor();
    logic [20:0] e;
    if ({bus.rs, bus.lcd_data} != prev_bus) last_chg = cyc;
    if (bus.enable && !prev_en) begin
      if (exp_q.size() == 0) begin
        check("exp_left", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("nibble", {bus.rs, bus.lcd_data}, e[4:0]);
        check("index", bus.index, e[12:5]);
        check("rw", bus.rw, 0);
        check("setup", (cyc - last_chg >= T_SETUP), 1);
        check("ready_lvl", bus.ready, (nib_cnt >= NIB_INIT));
        if (nib_cnt == 0) check("pwr_wait", cyc - rel_cyc, T_POWERUP + T_SETUP);
        else check("spacing", cyc - last_fall,
                   (cur_wait == 0) ? T_GAP + T_SETUP : cur_wait + 1 + T_SETUP);
`ifdef LCD_FRAME_DONE_EN
        if (e == {8'd0, 8'h00, 1'b0, 4'h8}) begin
          check("frame_pulses", fd_cnt, (nib_cnt == NIB_INIT) ? 0 : 1);
          fd_cnt = 0;
        end
`endif
        cur_wait = int'(e[20:13]);
        rise_cyc = cyc;
        nib_cnt++;
        if (bus.rs) noise = 8'($urandom);
      end
    end
    if (!bus.enable && prev_en) begin
      check("e_high", cyc - rise_cyc, T_EHIGH);
      check("hold", (last_chg < rise_cyc), 1);
      last_fall = cyc;
      last_idx  = bus.index;
      if (nib_cnt == NIB_INIT) clear_fall = cyc;
    end
    if (bus.ready && !prev_ready) check("ready_rise", cyc - clear_fall, T_CLEAR + 1);
`ifdef LCD_FRAME_DONE_EN
    if (frame_done) begin
      check("fd_time", cyc - last_fall, T_CMD);
      check("fd_index", last_idx, 8'h4F);
      fd_cnt++;
    end
`endif
    prev_en    = bus.enable;
    prev_ready = bus.ready;
    prev_bus   = {bus.rs, bus.lcd_data};
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input int frames);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_enable", bus.enable, 0);
    check("rst_rs", bus.rs, 0);
    check("rst_rw", bus.rw, 0);
    check("rst_data", bus.lcd_data, 0);
    check("rst_index", bus.index, 0);
    check("rst_ready", bus.ready, 0);
    build_expected(frames);
    prev_en = 1'b0; prev_ready = 1'b0; prev_bus = 5'd0;
    last_chg = cyc; rise_cyc = 0; last_fall = 0; clear_fall = -100000;
    cur_wait = 0; nib_cnt = 0; fd_cnt = 0; last_idx = 8'h00;
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (nib_cnt < target && n < budget) begin
      @(negedge clk);
      monitor();
      n++;
    end
    if (nib_cnt < target) check("timeout", nib_cnt, target);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < 128; i++) char_mem[i] = 8'($urandom_range(0, 255));
    char_mem[8'h00] = 8'h54;
    char_mem[8'h05] = 8'h00;
    char_mem[8'h0A] = 8'h20;
    char_mem[8'h47] = 8'h1F;
    char_mem[8'h4B] = 8'h7F;

    start_run(3);
    run_until(NIB_INIT + 2 * NIB_FRAME + 6, 20000);

    // Reset in the middle of a data E pulse.
    n = 0;
    while (!(bus.enable && bus.rs) && n < 500) begin
      @(negedge clk);
      monitor();
      n++;
    end
    check("char_e_found", (bus.enable && bus.rs), 1);
    #2 rst = 1'b1;
    #1;
    check("async_enable", bus.enable, 0);
    check("async_ready", bus.ready, 0);
    check("async_index", bus.index, 0);

    for (int i = 0; i < 128; i++) char_mem[i] = 8'($urandom_range(0, 63));
    char_mem[8'h4F] = 8'hFF;
    start_run(2);
    run_until(NIB_INIT + NIB_FRAME + 6, 10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
